// File: rtl/uart_tx_queue.sv
// uart_tx_queue: FIFO-buffered 16-bit word issuer for the uart TX side, with a fixed inter-word gap.
// Optional feature macro UART_TXQ_OVERFLOW_EN adds a sticky overflow flag (overflow/ovf_clr).
module uart_tx_queue #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned GAP_CYCLES = 8700
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [DATA_W-1:0]      wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   send_data,
    output logic [DATA_W-1:0]      tx_bits,
    input  logic                   tx_ready
`ifdef UART_TXQ_OVERFLOW_EN
    ,
    output logic                   overflow,
    input  logic                   ovf_clr
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [DATA_W-1:0]  tx_bits_q, tx_bits_d;
    logic               send_data_q, send_data_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [DATA_W-1:0]  mem_d [DEPTH];
    logic               pop;
    logic               push;
`ifdef UART_TXQ_OVERFLOW_EN
    logic               overflow_q, overflow_d;
`endif

    // Next-state: issue FSM, FIFO pointers/count and registered status flags
    always_comb begin
        state_d   = state_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        gap_d     = gap_q;
        tx_bits_d = tx_bits_q;
        mem_d     = mem_q;
        pop       = 1'b0;
        push      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if ((count_q != '0) && tx_ready) begin
                    pop       = 1'b1;
                    tx_bits_d = mem_q[rd_ptr_q];
                    rd_ptr_d  = rd_ptr_q + PTR_W'(1);
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                gap_d   = GAP_W'(GAP_CYCLES - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (gap_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A pop in the same cycle frees the slot the push is about to take
        push = wr_en && (!full_q || pop);
        if (push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end

        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end

        full_d      = (count_d == CNT_W'(DEPTH));
        empty_d     = (count_d == '0);
        send_data_d = (state_d == S_ISSUE);

`ifdef UART_TXQ_OVERFLOW_EN
        overflow_d = overflow_q;
        if (wr_en && !push) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
`endif
    end

    // State registers with synchronous active-low reset; storage array is not reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            gap_q       <= '0;
            tx_bits_q   <= '0;
            send_data_q <= 1'b0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
`ifdef UART_TXQ_OVERFLOW_EN
            overflow_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            gap_q       <= gap_d;
            tx_bits_q   <= tx_bits_d;
            send_data_q <= send_data_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            mem_q       <= mem_d;
`ifdef UART_TXQ_OVERFLOW_EN
            overflow_q  <= overflow_d;
`endif
        end
    end

    assign full      = full_q;
    assign empty     = empty_q;
    assign count     = count_q;
    assign send_data = send_data_q;
    assign tx_bits   = tx_bits_q;
`ifdef UART_TXQ_OVERFLOW_EN
    assign overflow  = overflow_q;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: queue-based reference model with per-cycle compare, directed scenarios and random traffic.
// Builds with or without UART_TXQ_OVERFLOW_EN.
module tb_uart_tx_queue;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned GAP    = 8;
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic              send_data;
    logic [DATA_W-1:0] tx_bits;
    logic              tx_ready;
`ifdef UART_TXQ_OVERFLOW_EN
    logic              overflow;
    logic              ovf_clr;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    uart_tx_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .send_data (send_data),
        .tx_bits   (tx_bits),
        .tx_ready  (tx_ready)
`ifdef UART_TXQ_OVERFLOW_EN
        ,
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
`endif
    );

    // uart stand-in: ready drops for 2 cycles after each strobe, plus a test override
    logic hold_low = 1'b0;
    int   drop_cnt = 0;
    assign tx_ready = !hold_low && (drop_cnt == 0);
    always @(negedge clk) begin
        if (send_data === 1'b1) drop_cnt <= 2;
        else if (drop_cnt > 0) drop_cnt <= drop_cnt - 1;
    end

    // Reference model: a word queue plus the earliest edge at which the next issue may happen
    logic [DATA_W-1:0] mq[$];
    int unsigned       edge_n  = 0;
    int unsigned       next_ok = 0;
    bit                m_valid = 1'b0;
    bit                m_send  = 1'b0;
    logic [DATA_W-1:0] m_tx    = '0;
    bit                m_pop;
    bit                m_drop;
    bit                m_ovf   = 1'b0;

    always @(posedge clk) begin
        edge_n++;
        if (rst_n === 1'b0) begin
            mq.delete();
            m_send  = 1'b0;
            m_tx    = '0;
            m_ovf   = 1'b0;
            next_ok = edge_n + 1;
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_pop  = (edge_n >= next_ok) && (mq.size() > 0) && (tx_ready === 1'b1);
            m_send = m_pop;
            if (m_pop) begin
                m_tx    = mq.pop_front();
                next_ok = edge_n + GAP + 2;
            end
            m_drop = 1'b0;
            if (wr_en === 1'b1) begin
                if (mq.size() < DEPTH) mq.push_back(wr_data);
                else m_drop = 1'b1;
            end
`ifdef UART_TXQ_OVERFLOW_EN
            if (m_drop) m_ovf = 1'b1;
            else if (ovf_clr === 1'b1) m_ovf = 1'b0;
`endif
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", nm, act, exp, edge_n);
        end
    endtask

    // Per-cycle compare against the model, and a log of every strobe
    int unsigned       log_t[$];
    logic [DATA_W-1:0] log_d[$];
    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_count", 32'(count), 32'(mq.size()));
            chk("model_empty", 32'(empty), 32'(mq.size() == 0));
            chk("model_full", 32'(full), 32'(mq.size() == DEPTH));
            chk("model_send", 32'(send_data), 32'(m_send));
            chk("model_tx_bits", 32'(tx_bits), 32'(m_tx));
`ifdef UART_TXQ_OVERFLOW_EN
            chk("model_overflow", 32'(overflow), 32'(m_ovf));
`endif
            if (send_data === 1'b1) begin
                log_t.push_back(edge_n);
                log_d.push_back(tx_bits);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [DATA_W-1:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic clear_log();
        log_t.delete();
        log_d.delete();
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
`ifdef UART_TXQ_OVERFLOW_EN
        ovf_clr = 1'b0;
`endif
        tick(2);
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_full", 32'(full), 32'd0);
        chk("reset_send", 32'(send_data), 32'd0);
        chk("reset_tx_bits", 32'(tx_bits), 32'd0);
        rst_n = 1'b1;

        // 1: single word latency
        push(16'hA55A);
        chk("t1_count_after_push", 32'(count), 32'd1);
        chk("t1_no_send_yet", 32'(send_data), 32'd0);
        tick(1);
        chk("t1_send", 32'(send_data), 32'd1);
        chk("t1_tx_bits", 32'(tx_bits), 32'hA55A);
        chk("t1_empty", 32'(empty), 32'd1);
        tick(1);
        chk("t1_send_one_cycle", 32'(send_data), 32'd0);
        tick(12);

        // 2: three words, spacing GAP+2
        clear_log();
        push(16'h0001);
        push(16'h0002);
        push(16'h0003);
        tick(40);
        chk("t2_pulses", 32'(log_t.size()), 32'd3);
        if (log_t.size() == 3) begin
            chk("t2_word0", 32'(log_d[0]), 32'h0001);
            chk("t2_word1", 32'(log_d[1]), 32'h0002);
            chk("t2_word2", 32'(log_d[2]), 32'h0003);
            chk("t2_gap01", log_t[1] - log_t[0], 32'd10);
            chk("t2_gap12", log_t[2] - log_t[1], 32'd10);
        end

        // 3: overflow with tx_ready held low
        hold_low = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push(16'(16'h10 + i));
            if (i == 2) chk("t3_not_full_at_3", 32'(full), 32'd0);
            if (i == 3) chk("t3_full_at_4", 32'(full), 32'd1);
        end
        chk("t3_count", 32'(count), 32'd4);
        chk("t3_full", 32'(full), 32'd1);
`ifdef UART_TXQ_OVERFLOW_EN
        chk("t3_overflow_set", 32'(overflow), 32'd1);
        tick(3);
        chk("t3_overflow_sticky", 32'(overflow), 32'd1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        chk("t3_overflow_clr", 32'(overflow), 32'd0);
`endif
        clear_log();
        hold_low = 1'b0;
        tick(50);
        chk("t3_pulses", 32'(log_t.size()), 32'd4);
        for (int i = 0; i < 4 && i < log_d.size(); i++)
            chk("t3_word", 32'(log_d[i]), 32'(16'h10 + i));

        // 4: push while full in the same cycle as the pop
        hold_low = 1'b1;
        for (int i = 0; i < 4; i++) push(16'(16'h20 + i));
        clear_log();
        hold_low = 1'b0;
        wr_en    = 1'b1;
        wr_data  = 16'h0024;
        tick(1);
        wr_en    = 1'b0;
        chk("t4_count", 32'(count), 32'd4);
        chk("t4_full", 32'(full), 32'd1);
        chk("t4_send", 32'(send_data), 32'd1);
        chk("t4_tx_bits", 32'(tx_bits), 32'h0020);
        tick(50);
        chk("t4_pulses", 32'(log_t.size()), 32'd5);
        for (int i = 0; i < 5 && i < log_d.size(); i++)
            chk("t4_word", 32'(log_d[i]), 32'(16'h20 + i));

        // 5: stall on tx_ready=0
        hold_low = 1'b1;
        push(16'h0030);
        push(16'h0031);
        clear_log();
        tick(50);
        chk("t5_stalled", 32'(log_t.size()), 32'd0);
        chk("t5_count", 32'(count), 32'd2);
        hold_low = 1'b0;
        tick(1);
        chk("t5_send", 32'(send_data), 32'd1);
        chk("t5_tx_bits", 32'(tx_bits), 32'h0030);
        tick(30);

        // 6: reset during WAIT
        hold_low = 1'b1;
        for (int i = 0; i < 4; i++) push(16'(16'h40 + i));
        hold_low = 1'b0;
        tick(1);
        chk("t6_send", 32'(send_data), 32'd1);
        tick(3);
        chk("t6_count_wait", 32'(count), 32'd3);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_empty", 32'(empty), 32'd1);
        chk("t6_send", 32'(send_data), 32'd0);
        chk("t6_tx_bits", 32'(tx_bits), 32'd0);
        clear_log();
        tick(30);
        chk("t6_no_pulses", 32'(log_t.size()), 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            wr_en   = ($urandom_range(0, 2) == 0);
            wr_data = 16'($urandom);
            if ($urandom_range(0, 39) == 0) hold_low = ~hold_low;
            rst_n   = ($urandom_range(0, 399) != 0);
`ifdef UART_TXQ_OVERFLOW_EN
            ovf_clr = ($urandom_range(0, 29) == 0);
`endif
            tick(1);
        end
        wr_en    = 1'b0;
        rst_n    = 1'b1;
        hold_low = 1'b0;
`ifdef UART_TXQ_OVERFLOW_EN
        ovf_clr  = 1'b0;
`endif
        tick(60);
        chk("drain_empty", 32'(empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_queue.md
Name: uart_tx_queue

Overview:
- Word-wide transmit queue that sits directly upstream of the uart block's TX side.
- Buffers 16-bit words from the processing logic in a FIFO and issues them to the uart one at a time:
  - drives the uart's send_data and tx_bits inputs;
  - samples the uart's tx_ready output.
- Holds a fixed inter-word gap so the serializer finishes both bytes before the next word is issued. The uart does not itself wait for the serializer.

Parameters:
- DATA_W, 16: word width; must equal n_tx_bytes*8 of the downstream uart.
- DEPTH, 16: FIFO entries; power of 2, minimum 2.
- GAP_CYCLES, 8700: clocks spent in WAIT after each issue; minimum 1. Default covers 2 frames of 10 bits at 434 clk/bit, plus margin.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous reset, active-low
- wr_en  in  1  push wr_data this cycle
- wr_data  in  DATA_W  word to queue
- full  out  1  FIFO holds DEPTH words
- empty  out  1  FIFO holds 0 words
- count  out  $clog2(DEPTH)+1  words currently held
- send_data  out  1  one-cycle issue strobe to uart
- tx_bits  out  DATA_W  word to uart; low byte is transmitted first by uart
- tx_ready  in  1  uart ready flag (high when uart is not issuing)

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - count=0, empty=1, full=0;
  - read/write pointers=0;
  - state=IDLE, gap counter=0;
  - send_data=0, tx_bits=0.
  - Reset applied mid-WAIT or mid-ISSUE aborts immediately and discards queued words. The word already strobed stays with the uart.
- FIFO:
  - Circular buffer, pointers $clog2(DEPTH) bits wide, wrap from DEPTH-1 to 0. count is tracked explicitly.
  - Push is accepted when wr_en=1 and (full=0 or a pop occurs the same cycle).
  - Push while full without a pop is dropped; contents and count are unchanged.
  - Pop occurs only on the IDLE->ISSUE transition.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - full/empty/count are registered and reflect state after the edge.
- State machine (registered):
  - IDLE: if count>0 and tx_ready=1, then:
    - load tx_bits <= mem[rd_ptr];
    - advance rd_ptr;
    - go to ISSUE.
    - Otherwise stay in IDLE.
  - ISSUE: send_data=1 for exactly this one cycle. Load gap counter with GAP_CYCLES-1. Go to WAIT.
  - WAIT: decrement the counter. When the counter is 0, go to IDLE.
- send_data is decoded from state==ISSUE only, so it is high for exactly 1 cycle per word.
- tx_bits is held stable from the ISSUE cycle until the next ISSUE load.
- Latency:
  - A word pushed at edge t into an empty queue, in IDLE with tx_ready=1, sees count=1 after t.
  - The IDLE decision is made at edge t+1, and send_data is high during the cycle following edge t+1.
- Spacing: consecutive send_data pulses are exactly GAP_CYCLES+2 cycles apart when the queue stays non-empty and tx_ready=1.
- tx_ready=0 in IDLE stalls the issue indefinitely. No timeout.
- Ordering: strict FIFO; no word is lost except on a dropped push or on reset.

Optional Feature:
- Macro: UART_TXQ_OVERFLOW_EN.
- When defined, the block adds output overflow (1 bit) and input ovf_clr (1 bit):
  - overflow goes high the cycle after any dropped push and stays high (sticky);
  - it is cleared to 0 by reset or by ovf_clr=1;
  - if a dropped push and ovf_clr coincide, overflow ends 1.
- When undefined, neither port exists and dropped pushes are silent.

Test Plan:
Use GAP_CYCLES=8, DEPTH=4, with a uart model that drops tx_ready for 2 cycles after each send_data.
1. Reset, then push 0xA55A at cycle 0 -> count=1 after the edge, send_data high for 1 cycle with tx_bits=0xA55A, empty=1 afterwards.
2. Push 0x0001, 0x0002, 0x0003 back-to-back -> three send_data pulses exactly 10 cycles apart, in order 0x0001, 0x0002, 0x0003; tx_bits stable between pulses.
3. Push 5 words 0x10..0x14 with no pops possible (tx_ready held 0) -> full=1 after the 4th, 0x14 dropped, count=4. Releasing tx_ready then outputs 0x10..0x13 only. With UART_TXQ_OVERFLOW_EN, overflow=1 until ovf_clr is pulsed.
4. Full queue with a push in the same cycle as the IDLE->ISSUE pop -> push accepted, count stays 4, and the new word appears last.
5. Hold tx_ready=0 with 2 words queued for 50 cycles -> no send_data. Raise tx_ready -> send_data 1 cycle later.
6. Assert rst_n=0 for 1 cycle during WAIT with 3 words queued -> next cycle count=0, empty=1, send_data=0, tx_bits=0, and no further pulses are issued.
